// File: rtl/alu_mul_seq_pkg.sv
// Shared ALU function codes and multiplier FSM state encodings.
// Imported by the multiplier controller and EX-stage glue.
package alu_mul_seq_pkg;

  localparam logic [3:0] FUNC_AND  = 4'b0000;
  localparam logic [3:0] FUNC_OR   = 4'b0001;
  localparam logic [3:0] FUNC_XOR  = 4'b0010;
  localparam logic [3:0] FUNC_XNOR = 4'b0011;
  localparam logic [3:0] FUNC_ADD  = 4'b0100;
  localparam logic [3:0] FUNC_SUB  = 4'b1100;
  localparam logic [3:0] FUNC_SLT  = 4'b0101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } mul_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier sequencer borrowing the EX-stage ALU adder.
// Produces the low WIDTH bits of op_a*op_b, one multiplier bit per cycle.
module alu_mul_seq
  import alu_mul_seq_pkg::*;
#(
  parameter int          WIDTH    = 32,
  parameter logic [3:0]  FUNC_ADD = 4'b0100,
  parameter int          CNT_W    = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             alu_sel,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [3:0]       alu_func,
  input  logic [WIDTH-1:0] alu_out
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  mul_state_e       state, state_nxt;
  logic [WIDTH-1:0] acc, mcand, mplier;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc_nxt;
  logic             run_last;

  assign acc_nxt  = mplier[0] ? alu_out : acc;
  assign run_last = (mplier[WIDTH-1:1] == '0) || (cnt == CNT_LAST);

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (!flush && start)
          state_nxt = (op_b == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        if (flush)
          state_nxt = ST_IDLE;
        else if (run_last)
          state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  // Flush freezes the datapath so result keeps its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      result <= '0;
    end else if (!flush) begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            acc    <= '0;
            mcand  <= op_a;
            mplier <= op_b;
            cnt    <= '0;
            if (op_b == '0)
              result <= '0;
          end
        end
        ST_RUN: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
          if (run_last)
            result <= acc_nxt;
        end
        default: ;
      endcase
    end
  end

  assign ready    = (state == ST_IDLE);
  assign busy     = (state == ST_RUN) || (state == ST_DONE);
  assign done     = (state == ST_DONE);
  assign alu_sel  = (state == ST_RUN);
  assign alu_in1  = acc;
  assign alu_in2  = mcand;
  assign alu_func = FUNC_ADD;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed bench for alu_mul_seq with a behavioural ALU beside it.
// Each task drives one scenario and checks its own expectations.
module tb_alu_mul_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         flush = 1'b0;
  logic         ready, busy, done, alu_sel;
  logic [W-1:0] result, alu_in1, alu_in2, alu_out;
  logic [3:0]   alu_func;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  always_comb begin
    alu_out = '0;
    unique case (alu_func)
      4'b0000: alu_out = alu_in1 & alu_in2;
      4'b0001: alu_out = alu_in1 | alu_in2;
      4'b0010: alu_out = alu_in1 ^ alu_in2;
      4'b0100: alu_out = alu_in1 + alu_in2;
      4'b1100: alu_out = alu_in1 - alu_in2;
      default: alu_out = '0;
    endcase
  end

  alu_mul_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op_a     (op_a),
    .op_b     (op_b),
    .flush    (flush),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .alu_sel  (alu_sel),
    .alu_in1  (alu_in1),
    .alu_in2  (alu_in2),
    .alu_func (alu_func),
    .alu_out  (alu_out)
  );

  // Start at the next edge, then sample 1ns after each edge until done.
  // lat = edges after the start edge before done is seen (-1 on timeout).
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output int runs,
                        output int bad_func, output int bad_busy);
    lat = -1;
    runs = 0;
    bad_func = 0;
    bad_busy = 0;
    op_a = a;
    op_b = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (alu_sel) begin
        runs++;
        if (alu_func !== 4'b0100) bad_func++;
      end
      if (busy !== 1'b1 || ready !== 1'b0) bad_busy++;
      if (done === 1'b1) begin
        lat = i;
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    total++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    else
      pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    chk("rst_ready", W'(ready), 1);
    chk("rst_busy", W'(busy), 0);
    chk("rst_done", W'(done), 0);
    chk("rst_alu_sel", W'(alu_sel), 0);
    chk("rst_result", result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_mul(input string name, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp,
                          input int exp_runs);
    int lat, runs, bf, bb;
    run_op(a, b, lat, runs, bf, bb);
    chk({name, "_result"}, result, exp);
    chk({name, "_runs"}, W'(runs), W'(exp_runs));
    chk({name, "_latency"}, W'(lat), W'(exp_runs));
    chk({name, "_func"}, W'(bf), 0);
    chk({name, "_busy"}, W'(bb), 0);
    chk({name, "_ready_after"}, W'(ready), 1);
  endtask

  task automatic test_restart_ignored();
    int seen_done;
    seen_done = 0;
    op_a = 5;
    op_b = 10;
    start = 1'b1;
    @(posedge clk);
    #1;
    op_a = 3;
    op_b = 3;
    for (int i = 0; i < 40 && seen_done == 0; i++) begin
      if (done === 1'b1) seen_done = 1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    start = 1'b0;
    chk("restart_done_seen", W'(seen_done), 1);
    chk("restart_result", result, 50);
    @(posedge clk);
    #1;
  endtask

  task automatic test_flush();
    int seen_done;
    seen_done = 0;
    op_a = 7;
    op_b = 15;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (done === 1'b1) seen_done++;
    @(posedge clk);
    #1;
    if (done === 1'b1) seen_done++;
    chk("flush_in_run", W'(alu_sel), 1);
    flush = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    start = 1'b0;
    chk("flush_ready", W'(ready), 1);
    chk("flush_busy", W'(busy), 0);
    for (int i = 0; i < 8; i++) begin
      if (done === 1'b1) seen_done++;
      @(posedge clk);
      #1;
    end
    chk("flush_no_done", W'(seen_done), 0);
    chk("flush_result_kept", result, 50);
  endtask

  task automatic test_async_reset();
    op_a = 9;
    op_b = 32'hFF;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("arst_pre_sel", W'(alu_sel), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_alu_sel", W'(alu_sel), 0);
    chk("arst_ready", W'(ready), 1);
    chk("arst_busy", W'(busy), 0);
    chk("arst_result", result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("arst_ready_after", W'(ready), 1);
  endtask

  initial begin
    test_reset();
    test_mul("b10", 32'd5, 32'd10, 32'd50, 4);
    test_mul("neg", 32'hFFFFFFFF, 32'd3, 32'hFFFFFFFD, 2);
    test_mul("zero", 32'd123, 32'd0, 32'd0, 0);
    test_mul("wrap", 32'h10000, 32'h10000, 32'd0, 17);
    test_mul("msb", 32'd1, 32'h80000000, 32'h80000000, 32);
    test_mul("b10b", 32'd5, 32'd10, 32'd50, 4);
    test_restart_ignored();
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
